render_controller: RTL
======================

# render_controller

Frame-level sequencer for the GPU pipeline; it replaces the ad-hoc timer/state logic in the top level. It paces rendering to a fixed frame period and starts matrix generation. It releases vertex fetch once the back buffer is cleared, detects pipeline drain, and requests framebuffer swap/clear only for fully rendered frames. It also keeps frame, pixel and overrun statistics for the seven-segment display.

## Interface
Parameters:
- FRAME_PERIOD, 2_000_000: gpu_clk cycles per frame tick.
- DRAIN_QUIET, 16: consecutive idle cycles required to declare the pipeline drained.
- STAT_WIDTH, 16: width of the statistics counters.

Ports:
- clk_in  in  1  gpu_clk; single clock domain.
- rst_in  in  1  synchronous, active-high reset.
- enable_in  in  1  permits new frames to start.
- matrix_start_out  out  1  one-cycle pulse to matrix_gen valid_in.
- matrix_valid_in  in  1  matrix_gen column output valid.
- fetch_rst_out  out  1  hold vertex_fetch in reset; low only while rendering.
- fetch_done_in  in  1  vertex_fetch has emitted its last vertex (level).
- pipeline_busy_in  in  1  OR of stage valids, fifo non-empty and !rasterizer_ready.
- framebuffer_ready_in  in  1  back buffer clear complete.
- pixel_valid_in  in  1  fragment_shader output valid.
- fb_switch_out  out  1  one-cycle buffer swap pulse.
- fb_clear_out  out  1  one-cycle back-buffer clear pulse.
- frame_done_out  out  1  one-cycle pulse when a frame finishes draining.
- frame_count_out  out  STAT_WIDTH  frames swapped since reset; wraps.
- pixel_count_out  out  STAT_WIDTH  pixels in the last completed frame; saturating.
- overrun_count_out  out  STAT_WIDTH  ticks missed; saturating.
- state_out  out  3  current state encoding, for debug.

## Operation
- All outputs are registered.
- Reset values: fetch_rst_out=1; all other outputs 0; state=Idle; timer=0.
- Frame timer: counts 0..FRAME_PERIOD-1 and wraps. tick is asserted on the cycle the timer equals FRAME_PERIOD-1.
- States:
  - Idle: on tick with enable_in=1, pulse fb_clear_out (no switch) and go to Matrix.
  - Matrix: assert matrix_start_out on the entry cycle only. On matrix_valid_in, go to WaitBuffer.
  - WaitBuffer: on framebuffer_ready_in=1, go to Render.
  - Render: fetch_rst_out=0. On fetch_done_in, go to Drain.
  - Drain: fetch_rst_out=0. A quiet counter counts cycles with pipeline_busy_in=0 and resets to 0 on any busy cycle. When the counter reaches DRAIN_QUIET: latch pixel_count_out, pulse frame_done_out, set fetch_rst_out=1, go to WaitTick.
  - WaitTick: on tick, pulse fb_switch_out and fb_clear_out and increment frame_count_out. Then go to Matrix if enable_in=1, otherwise Idle.
- Pixel accumulator: cleared on Matrix entry. Counts pixel_valid_in only in Render and Drain.
- Overrun: a tick in any state other than Idle or WaitTick increments overrun_count_out. There is no swap; rendering continues, and the swap occurs on the first tick after reaching WaitTick.
- Ignored inputs: matrix_valid_in outside Matrix, and fetch_done_in outside Render.
- A tick on the same cycle as Drain→WaitTick counts as an overrun.
- enable_in dropping mid-frame: the current frame completes and swaps, then the controller idles.
- Reset mid-operation: all registers return to reset values on the next edge.

## Timing
- Tick at cycle T: switch/clear pulses and matrix_start_out are high at T+1, concurrent with Matrix entry.
- framebuffer_ready_in high at cycle R in WaitBuffer: fetch_rst_out=0 at R+1.
- fetch_done_in high at cycle F in Render: Drain from F+1. With no busy cycles, frame_done_out at F+DRAIN_QUIET+1.
- The frame timer free-runs regardless of state; only rst_in clears it.

## Structure
- render_pkg holds:
  - the state enum typedef (Idle, Matrix, WaitBuffer, Render, Drain, WaitTick; 3-bit encoding matches state_out);
  - default constants FRAME_PERIOD_DEFAULT and DRAIN_QUIET_DEFAULT.
- Sub-module frame_timer (parameter FRAME_PERIOD; ports clk_in, rst_in, tick_out) holds the free-running counter.
- Saturating statistics counters are implemented inline.

## Test plan
Benches use FRAME_PERIOD=100 and DRAIN_QUIET=4.
- Reset: pulse rst_in -> fetch_rst_out=1, all pulses 0, counts 0, state_out=Idle.
- First frame:
  - enable_in=1 -> at cycle 100 fb_clear_out=1, fb_switch_out=0, matrix_start_out=1.
  - matrix_valid_in at 110, framebuffer_ready_in at 120 -> fetch_rst_out=0 at 121.
  - 50 pixel pulses, fetch_done_in at 150, busy low -> frame_done_out at 155, pixel_count_out=50.
  - At 200: fb_switch_out=fb_clear_out=1, frame_count_out=1.
- Overrun: hold fetch_done_in low until 250 -> overrun_count_out=1 at 200 with no switch. Switch then occurs at 300.
- Drain glitch: busy low for 3 cycles, high for 1, then low -> frame_done_out appears only 4 cycles after the last busy cycle.
- Mid-frame reset: rst_in during Render -> next cycle fetch_rst_out=1, counters 0, timer restarts at 0.
- Disable: enable_in=0 during Render -> frame completes, swap at next tick, state_out=Idle, no further matrix_start_out.

Source files
------------

// File: rtl/render_pkg.sv
// Shared types and defaults for the frame-level render sequencer.
package render_pkg;

   localparam int FRAME_PERIOD_DEFAULT = 2_000_000;
   localparam int DRAIN_QUIET_DEFAULT  = 16;
   localparam int STAT_WIDTH_DEFAULT   = 16;

   // Encoding is exported on state_out for debug, so keep values stable.
   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_MATRIX      = 3'd1,
      ST_WAIT_BUFFER = 3'd2,
      ST_RENDER      = 3'd3,
      ST_DRAIN       = 3'd4,
      ST_WAIT_TICK   = 3'd5
   } render_state_t;

   // Vertex fetch runs, and fragments are counted, only in these states.
   function automatic logic is_fetching(input render_state_t s);
      return (s == ST_RENDER) || (s == ST_DRAIN);
   endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running frame period counter; tick_out marks the last cycle of each period.
module frame_timer
   import render_pkg::*;
#(
   parameter int FRAME_PERIOD = FRAME_PERIOD_DEFAULT
) (
   input  logic clk_in,
   input  logic rst_in,
   output logic tick_out
);

   localparam int CW = (FRAME_PERIOD > 1) ? $clog2(FRAME_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(FRAME_PERIOD - 1);

   logic [CW-1:0] count;

   // Count 0..FRAME_PERIOD-1 and wrap; only reset clears it, the FSM never touches it.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tick_out = (count == LAST);

endmodule

// File: rtl/render_controller.sv
// Frame sequencer: paces frames to the timer tick, gates vertex fetch, detects
// pipeline drain and issues buffer swap/clear, plus display statistics.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// IDLE        | no frame in flight; waits for tick with enable_in
// MATRIX      | matrix_gen started; waits for its first valid column
// WAIT_BUFFER | waits for back-buffer clear to complete
// RENDER      | vertex fetch released; waits for fetch_done_in
// DRAIN       | waits for DRAIN_QUIET consecutive idle pipeline cycles
// WAIT_TICK   | frame complete; swap on next tick
module render_controller
   import render_pkg::*;
#(
   parameter int FRAME_PERIOD = FRAME_PERIOD_DEFAULT,
   parameter int DRAIN_QUIET  = DRAIN_QUIET_DEFAULT,
   parameter int STAT_WIDTH   = STAT_WIDTH_DEFAULT
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  enable_in,
   output logic                  matrix_start_out,
   input  logic                  matrix_valid_in,
   output logic                  fetch_rst_out,
   input  logic                  fetch_done_in,
   input  logic                  pipeline_busy_in,
   input  logic                  framebuffer_ready_in,
   input  logic                  pixel_valid_in,
   output logic                  fb_switch_out,
   output logic                  fb_clear_out,
   output logic                  frame_done_out,
   output logic [STAT_WIDTH-1:0] frame_count_out,
   output logic [STAT_WIDTH-1:0] pixel_count_out,
   output logic [STAT_WIDTH-1:0] overrun_count_out,
   output logic [2:0]            state_out
);

   localparam int QW = (DRAIN_QUIET > 1) ? $clog2(DRAIN_QUIET) : 1;
   localparam logic [QW-1:0]         QUIET_LAST = QW'(DRAIN_QUIET - 1);
   localparam logic [STAT_WIDTH-1:0] STAT_ONE   = STAT_WIDTH'(1);

   render_state_t state;
   render_state_t state_nxt;

   logic                  tick;
   logic                  drained;
   logic                  pix_add;
   logic                  overrun_hit;
   logic                  start_nxt;
   logic                  switch_nxt;
   logic                  clear_nxt;
   logic                  fetch_rst_nxt;
   logic [QW-1:0]         quiet;
   logic [STAT_WIDTH-1:0] acc;
   logic [STAT_WIDTH-1:0] acc_nxt;

   frame_timer #(
      .FRAME_PERIOD (FRAME_PERIOD)
   ) u_frame_timer (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .tick_out (tick)
   );

   // Next state and next values of the registered control pulses.
   always_comb begin
      state_nxt     = state;
      // Drain completes on the cycle that would bring the quiet count to DRAIN_QUIET.
      drained       = (state == ST_DRAIN) && !pipeline_busy_in && (quiet == QUIET_LAST);
      pix_add       = is_fetching(state) && pixel_valid_in;
      acc_nxt       = (pix_add && (acc != '1)) ? acc + STAT_ONE : acc;
      // A tick outside IDLE/WAIT_TICK means the frame missed its slot; it keeps rendering.
      overrun_hit   = tick && (state != ST_IDLE) && (state != ST_WAIT_TICK);
      switch_nxt    = (state == ST_WAIT_TICK) && tick;
      clear_nxt     = switch_nxt || ((state == ST_IDLE) && tick && enable_in);

      unique case (state)
         ST_IDLE:        if (tick && enable_in)    state_nxt = ST_MATRIX;
         ST_MATRIX:      if (matrix_valid_in)      state_nxt = ST_WAIT_BUFFER;
         ST_WAIT_BUFFER: if (framebuffer_ready_in) state_nxt = ST_RENDER;
         ST_RENDER:      if (fetch_done_in)        state_nxt = ST_DRAIN;
         ST_DRAIN:       if (drained)              state_nxt = ST_WAIT_TICK;
         ST_WAIT_TICK:   if (tick)                 state_nxt = enable_in ? ST_MATRIX : ST_IDLE;
         default:                                  state_nxt = ST_IDLE;
      endcase

      start_nxt     = (state_nxt == ST_MATRIX) && (state != ST_MATRIX);
      fetch_rst_nxt = !is_fetching(state_nxt);
   end

   // State register and registered control outputs.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state            <= ST_IDLE;
         matrix_start_out <= 1'b0;
         fetch_rst_out    <= 1'b1;
         fb_switch_out    <= 1'b0;
         fb_clear_out     <= 1'b0;
         frame_done_out   <= 1'b0;
      end else begin
         state            <= state_nxt;
         matrix_start_out <= start_nxt;
         fetch_rst_out    <= fetch_rst_nxt;
         fb_switch_out    <= switch_nxt;
         fb_clear_out     <= clear_nxt;
         frame_done_out   <= drained;
      end
   end

   // Quiet-cycle counter and per-frame pixel accumulator.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         quiet <= '0;
         acc   <= '0;
      end else begin
         if ((state == ST_DRAIN) && !pipeline_busy_in && !drained) begin
            quiet <= quiet + QW'(1);
         end else begin
            quiet <= '0;
         end
         acc <= start_nxt ? '0 : acc_nxt;
      end
   end

   // Display statistics: wrapping frame count, saturating pixel and overrun counts.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         frame_count_out   <= '0;
         pixel_count_out   <= '0;
         overrun_count_out <= '0;
      end else begin
         if (switch_nxt) begin
            frame_count_out <= frame_count_out + STAT_ONE;
         end
         if (drained) begin
            pixel_count_out <= acc_nxt;
         end
         if (overrun_hit && (overrun_count_out != '1)) begin
            overrun_count_out <= overrun_count_out + STAT_ONE;
         end
      end
   end

   assign state_out = state;

endmodule
